// File: rtl/buzz_pkg.sv
// Shared types and constants for the buzzer tone scheduler: FSM states,
// tone index, melody ROM and default half-period table.
package buzz_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MANUAL   = 2'd1,
    SEQ_NOTE = 2'd2,
    SEQ_GAP  = 2'd3
  } state_t;

  typedef logic [1:0] tone_t;

  localparam int CTR_W = 26;

  localparam int unsigned HP0_DEF = 5220000;
  localparam int unsigned HP1_DEF = 10465000;
  localparam int unsigned HP2_DEF = 6592600;
  localparam int unsigned HP3_DEF = 8800000;

  localparam tone_t SEQ_ROM [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

  // req[0] has highest priority
  function automatic tone_t lowest_req(input logic [3:0] r);
    tone_t t;
    casez (r)
      4'b???1: t = 2'd0;
      4'b??10: t = 2'd1;
      4'b?100: t = 2'd2;
      4'b1000: t = 2'd3;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/buzz_tone_divider.sv
// Shared square-wave divider: toggles buzz_out every HP[tone_sel]+1 cycles,
// restarted (counter and output cleared) whenever restart is high.
module buzz_tone_divider
  import buzz_pkg::*;
#(
  parameter int unsigned HP0 = HP0_DEF,
  parameter int unsigned HP1 = HP1_DEF,
  parameter int unsigned HP2 = HP2_DEF,
  parameter int unsigned HP3 = HP3_DEF
) (
  input  logic  clk_50MHz,
  input  logic  reset_button,
  input  logic  restart,
  input  tone_t tone_sel,
  output logic  buzz_out
);

  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] hp;

  always_comb begin
    case (tone_sel)
      2'd0:    hp = CTR_W'(HP0);
      2'd1:    hp = CTR_W'(HP1);
      2'd2:    hp = CTR_W'(HP2);
      default: hp = CTR_W'(HP3);
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      ctr      <= '0;
      buzz_out <= 1'b0;
    end else if (restart) begin
      ctr      <= '0;
      buzz_out <= 1'b0;
    end else if (ctr == hp) begin
      ctr      <= '0;
      buzz_out <= ~buzz_out;
    end else begin
      ctr <= ctr + CTR_W'(1);
    end
  end

endmodule

// File: rtl/buzz_tone_scheduler.sv
// Buzzer controller: arbitrates pushbutton tone requests against an 8-step
// melody sequencer and drives one shared square-wave divider.
module buzz_tone_scheduler
  import buzz_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned NOTE_MS  = 250,
  parameter int unsigned GAP_MS   = 50,
  parameter int unsigned HP0      = HP0_DEF,
  parameter int unsigned HP1      = HP1_DEF,
  parameter int unsigned HP2      = HP2_DEF,
  parameter int unsigned HP3      = HP3_DEF
) (
  input  logic       clk_50MHz,
  input  logic       reset_button,
  input  logic [3:0] req,
  input  logic       seq_start,
  input  logic       seq_stop,
  output logic       buzz_out,
  output tone_t      tone_sel,
  output logic       active,
  output logic [2:0] seq_step,
  output logic       seq_done
);

  localparam int TICK_W  = $clog2(TICK_DIV + 1);
  localparam int DUR_MAX = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  NOTE_LAST = DUR_W'(NOTE_MS - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_MS - 1);

  logic [3:0]        req_p0, req_p1;
  state_t            state;
  logic [TICK_W-1:0] tick_ctr;
  logic [DUR_W-1:0]  dur_ctr;
  logic              any_req, tick_last, note_end, gap_end, leave, restart;
  tone_t             winner;
  logic [2:0]        step_inc;

  assign any_req   = |req_p1;
  assign winner    = lowest_req(req_p1);
  assign tick_last = (tick_ctr == TICK_LAST);
  assign note_end  = (state == SEQ_NOTE) && tick_last && (dur_ctr == NOTE_LAST);
  assign gap_end   = (state == SEQ_GAP) && tick_last && (dur_ctr == GAP_LAST);
  assign step_inc  = seq_step + 3'd1;

  // leave is high exactly when the FSM will change state on this edge
  always_comb begin
    leave = 1'b0;
    case (state)
      IDLE:     leave = any_req || seq_start;
      MANUAL:   leave = !any_req;
      SEQ_NOTE: leave = any_req || seq_stop || note_end;
      SEQ_GAP:  leave = any_req || seq_stop || gap_end;
      default:  leave = 1'b0;
    endcase
  end

  assign restart = leave || (state == IDLE) || (state == SEQ_GAP) ||
                   ((state == MANUAL) && (winner != tone_sel));

  // Stage p0/p1: two-flop synchronizer for the asynchronous button requests
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      req_p0 <= '0;
      req_p1 <= '0;
    end else begin
      req_p0 <= req;
      req_p1 <= req_p0;
    end
  end

  // Tick prescaler and duration counter, cleared on every state entry
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      tick_ctr <= '0;
      dur_ctr  <= '0;
    end else if (leave) begin
      tick_ctr <= '0;
      dur_ctr  <= '0;
    end else if (tick_last) begin
      tick_ctr <= '0;
      dur_ctr  <= dur_ctr + DUR_W'(1);
    end else begin
      tick_ctr <= tick_ctr + TICK_W'(1);
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      state    <= IDLE;
      tone_sel <= 2'd0;
      active   <= 1'b0;
      seq_step <= 3'd0;
      seq_done <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= MANUAL;
            tone_sel <= winner;
            active   <= 1'b1;
          end else if (seq_start) begin
            state    <= SEQ_NOTE;
            seq_step <= 3'd0;
            tone_sel <= SEQ_ROM[0];
            active   <= 1'b1;
          end
        end
        MANUAL: begin
          if (!any_req) begin
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            tone_sel <= winner;
          end
        end
        SEQ_NOTE, SEQ_GAP: begin
          if (any_req) begin
            state    <= MANUAL;
            tone_sel <= winner;
            active   <= 1'b1;
            seq_step <= 3'd0;
          end else if (seq_stop) begin
            state    <= IDLE;
            active   <= 1'b0;
            seq_step <= 3'd0;
          end else if (note_end) begin
            state  <= SEQ_GAP;
            active <= 1'b0;
          end else if (gap_end) begin
            if (seq_step == 3'd7) begin
              state    <= IDLE;
              seq_step <= 3'd0;
              seq_done <= 1'b1;
            end else begin
              state    <= SEQ_NOTE;
              seq_step <= step_inc;
              tone_sel <= SEQ_ROM[step_inc];
              active   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  buzz_tone_divider #(
    .HP0(HP0),
    .HP1(HP1),
    .HP2(HP2),
    .HP3(HP3)
  ) u_divider (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .restart      (restart),
    .tone_sel     (tone_sel),
    .buzz_out     (buzz_out)
  );

endmodule

// File: tb/tb_buzz_tone_scheduler.sv
// Scoreboard bench for buzz_tone_scheduler: a behavioural model predicts every
// cycle's outputs from the melody timeline and request history.
module tb_buzz_tone_scheduler;

  localparam int NC      = 3 * 4;   // note cycles
  localparam int GC      = 2 * 4;   // gap cycles
  localparam int SLOT    = NC + GC;
  localparam int MEL_LEN = 8 * SLOT;

  logic       clk_50MHz = 1'b0;
  logic       reset_button = 1'b0;
  logic [3:0] req = 4'd0;
  logic       seq_start = 1'b0;
  logic       seq_stop = 1'b0;
  logic       buzz_out;
  logic [1:0] tone_sel;
  logic       active;
  logic [2:0] seq_step;
  logic       seq_done;

  buzz_tone_scheduler #(
    .TICK_DIV(4), .NOTE_MS(3), .GAP_MS(2),
    .HP0(3), .HP1(5), .HP2(7), .HP3(9)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .req          (req),
    .seq_start    (seq_start),
    .seq_stop     (seq_stop),
    .buzz_out     (buzz_out),
    .tone_sel     (tone_sel),
    .active       (active),
    .seq_step     (seq_step),
    .seq_done     (seq_done)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct packed {
    logic       buzz;
    logic [1:0] tone;
    logic       act;
    logic [2:0] step;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hp_tab[4] = '{3, 5, 7, 9};
  int   rom[8]    = '{0, 1, 2, 3, 3, 2, 1, 0};

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  // Reference model: mode 0 idle, 1 manual, 2 melody (k = cycles since start)
  initial begin : model
    int mode, tone, age, k, note, ph;
    logic [3:0] r1, r2, s;
    logic done;
    exp_t e;
    mode = 0; tone = 0; age = 0; k = 0; r1 = '0; r2 = '0;
    forever begin
      @(posedge clk_50MHz);
      done = 1'b0;
      if (reset_button) begin
        mode = 0; tone = 0; age = 0; k = 0; r1 = '0; r2 = '0;
      end else begin
        s  = r2;
        r2 = r1;
        r1 = req;
        case (mode)
          0: begin
            if (s != 0) begin mode = 1; tone = lowest(s); age = 0; end
            else if (seq_start) begin mode = 2; k = 0; end
          end
          1: begin
            if (s == 0) mode = 0;
            else if (lowest(s) != tone) begin tone = lowest(s); age = 0; end
            else age++;
          end
          default: begin
            if (s != 0) begin mode = 1; tone = lowest(s); age = 0; end
            else if (seq_stop) mode = 0;
            else begin
              k++;
              if (k == MEL_LEN) begin mode = 0; done = 1'b1; end
            end
          end
        endcase
      end
      e = '0;
      e.done = done;
      if (mode == 1) begin
        e.act  = 1'b1;
        e.buzz = ((age / (hp_tab[tone] + 1)) % 2) == 1;
      end else if (mode == 2) begin
        note   = k / SLOT;
        ph     = k % SLOT;
        tone   = rom[note];
        e.step = 3'(note);
        e.act  = (ph < NC);
        e.buzz = (ph < NC) && (((ph / (hp_tab[tone] + 1)) % 2) == 1);
      end
      e.tone = 2'(tone);
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_50MHz);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("buzz_out", int'(buzz_out), int'(e.buzz));
        check("tone_sel", int'(tone_sel), int'(e.tone));
        check("active",   int'(active),   int'(e.act));
        check("seq_step", int'(seq_step), int'(e.step));
        check("seq_done", int'(seq_done), int'(e.done));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic pulse_start();
    seq_start = 1'b1;
    @(negedge clk_50MHz);
    seq_start = 1'b0;
  endtask

  initial begin : stimulus
    int len;
    #1 reset_button = 1'b1;
    #2;
    check("reset_buzz", int'(buzz_out), 0);
    check("reset_active", int'(active), 0);
    idle(3);
    reset_button = 1'b0;
    idle(200);

    // Manual requests with a priority change, then release
    req = 4'b0100; idle(60);
    req = 4'b0101; idle(40);
    req = 4'b0000; idle(20);

    // Full melody
    pulse_start(); idle(180);

    // Melody preempted at step 4 by req[3], no resume after release
    pulse_start(); idle(85);
    req = 4'b1000; idle(40);
    req = 4'b0000; idle(40);

    // Stop wins over simultaneous start at step 2
    pulse_start(); idle(45);
    seq_start = 1'b1; seq_stop = 1'b1;
    @(negedge clk_50MHz);
    seq_start = 1'b0; seq_stop = 1'b0;
    idle(30);

    // Asynchronous reset mid-note, then replay from step 0
    pulse_start(); idle(30);
    #2 reset_button = 1'b1;
    #1;
    check("async_buzz",   int'(buzz_out), 0);
    check("async_tone",   int'(tone_sel), 0);
    check("async_active", int'(active),   0);
    check("async_step",   int'(seq_step), 0);
    check("async_done",   int'(seq_done), 0);
    idle(2);
    reset_button = 1'b0;
    pulse_start(); idle(180);

    // Randomized mix of requests, melodies and stray start/stop pulses
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 2) == 0) begin
        req = 4'($urandom_range(1, 15));
        len = $urandom_range(1, 60);
        for (int c = 0; c < len; c++) begin
          seq_start = ($urandom_range(0, 15) == 0);
          seq_stop  = ($urandom_range(0, 15) == 0);
          @(negedge clk_50MHz);
        end
      end else begin
        req = 4'd0;
        pulse_start();
        len = $urandom_range(20, 200);
        for (int c = 0; c < len; c++) begin
          seq_start = ($urandom_range(0, 60) == 0);
          seq_stop  = ($urandom_range(0, 150) == 0);
          @(negedge clk_50MHz);
        end
      end
      seq_start = 1'b0;
      seq_stop  = 1'b0;
    end
    req = 4'd0;
    idle(5);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buzz_tone_scheduler.md
# buzz_tone_scheduler

Controller for the board buzzer. It arbitrates four pushbutton tone requests and an autonomous 8-step melody sequencer, then configures a single shared square-wave divider that produces the buzzer output. It replaces per-tone free-running dividers and the level-latched select with one scheduled resource, and sits between the debounced button inputs and the buzzer pin.

## Interface
- TICK_DIV, 50000: clk_50MHz cycles per duration tick (1 ms).
- NOTE_MS, 250: ticks per sequencer note.
- GAP_MS, 50: ticks of silence after each note.
- HP0, 5220000: half-period terminal count for tone 0. HP1, 10465000: tone 1. HP2, 6592600: tone 2. HP3, 8800000: tone 3. Each must be < 2^26.
- clk_50MHz  in  1  system clock.
- reset_button  in  1  asynchronous, active-high reset.
- req  in  4  level tone requests, asynchronous to clk; req[0] is highest priority.
- seq_start  in  1  pulse; starts the melody from step 0.
- seq_stop  in  1  pulse; aborts the melody.
- buzz_out  out  1  square wave to the buzzer.
- tone_sel  out  2  tone currently driving the divider.
- active  out  1  high while buzz_out is toggling.
- seq_step  out  3  current melody step.
- seq_done  out  1  one-cycle pulse when step 7's gap completes.

## Operation
- req passes through a 2-flop synchronizer. seq_start and seq_stop are synchronous and are not synchronized.
- FSM states: IDLE, MANUAL, SEQ_NOTE, SEQ_GAP.
- IDLE:
  - any synced req goes to MANUAL;
  - otherwise seq_start goes to SEQ_NOTE with step 0.
- MANUAL:
  - tone_sel is the lowest set index of synced req.
  - A winner change restarts the divider.
  - All req low goes to IDLE.
  - seq_start and seq_stop are ignored.
- SEQ_NOTE: tone_sel = SEQ_ROM[seq_step]. After NOTE_MS ticks, go to SEQ_GAP.
- SEQ_GAP:
  - divider held and silent;
  - after GAP_MS ticks, if seq_step is 7, pulse seq_done and go to IDLE with seq_step set to 0;
  - otherwise increment seq_step and go to SEQ_NOTE.
- Preemption: any synced req in SEQ_NOTE or SEQ_GAP aborts the melody. Next state is MANUAL, seq_step is set to 0, and no seq_done is issued. The melody does not resume on release.
- seq_stop in SEQ_NOTE or SEQ_GAP goes to IDLE with seq_step set to 0. If seq_stop and seq_start arrive together, stop wins. seq_start during a melody is ignored.
- Divider:
  - 26-bit counter ctr; when ctr == HP[tone_sel], set ctr to 0 and toggle buzz_out, else increment ctr;
  - restart (ctr=0, buzz_out=0) on every FSM state change, every tone_sel change, and in IDLE and SEQ_GAP.
- Tick prescaler: counts 0..TICK_DIV-1 and is cleared on every state entry, so durations are exact (see Timing).
- active is 1 in MANUAL and SEQ_NOTE, 0 elsewhere.

## Timing
- Reset values: buzz_out=0, tone_sel=0, active=0, seq_step=0, seq_done=0; state IDLE; all counters 0; synchronizer flops 0.
- req edge to tone_sel and active update: 3 clk edges (2 synchronizer flops plus the FSM register).
- seq_start to active=1: 1 edge.
- buzz_out first rises HP[tone_sel]+1 cycles after a divider restart. Half-period is HP+1 cycles, full period 2·(HP+1).
- SEQ_NOTE lasts exactly NOTE_MS·TICK_DIV cycles; SEQ_GAP lasts exactly GAP_MS·TICK_DIV cycles.
- seq_done is asserted in the same cycle the state register becomes IDLE.
- Reset mid-operation returns all outputs to reset values immediately (asynchronous assertion). Deassertion is synchronized externally.

## Structure
- Package buzz_pkg holds:
  - the state enum (IDLE, MANUAL, SEQ_NOTE, SEQ_GAP);
  - the tone index type (2 bits);
  - SEQ_ROM constant = {0,1,2,3,3,2,1,0};
  - default HP table constants.
- Sub-module buzz_tone_divider contains the counter, terminal compare against the selected HP, and the restart input. Top level holds the synchronizer, prescaler, duration counter and FSM.

## Test plan
Sim parameters: TICK_DIV=4, NOTE_MS=3, GAP_MS=2, HP0..3=3,5,7,9.
- Reset, no stimulus: all outputs 0 for 200 cycles, buzz_out static.
- req=4'b0100 held: tone_sel=2 after 3 edges; buzz_out period 16 cycles. Then also set req[0]: tone_sel=0, divider restarts, period 8. Release all: active=0 and buzz_out=0 within 3 edges.
- seq_start pulse: tone sequence 0,1,2,3,3,2,1,0, each note 12 cycles active then 8 cycles silent. seq_done pulses once, 160 cycles after start; seq_step returns to 0.
- seq_start, then req[3] at step 4: abort to MANUAL with tone 3. No seq_done; seq_step=0; after release, IDLE with no resume.
- seq_stop at step 2 with simultaneous seq_start: IDLE, buzz_out=0, seq_step=0.
- reset_button asserted mid-note: outputs 0 asynchronously, before the next clock edge. After release, seq_start replays from step 0.
